mmio_joypad_mp: RTL and testbench

MMIO_JOYPAD_MP -- requirements
Module: mmio_joypad_mp

---
 rtl/mmio_joypad_mp.sv | 179 +++++++++++++++++
 tb/tb_mmio_joypad_mp.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_joypad_mp.sv
// Memory-mapped multi-pad joypad register (FF00).
// Raw active-low buttons are synchronised and debounced per bit. The sel
// field picks d-pad or face lines of the current pad. In multiplayer mode,
// sel=11 reports the current player id as 4'hF - cur. irq fires on any
// 1->0 edge of the line nibble.
module mmio_joypad_mp #(
  parameter int NUM_PADS        = 1,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*NUM_PADS-1:0] btn_n,
  input  logic [1:0]            mlt_mode,
  input  logic [15:0]           req_addr_select,
  input  logic                  req_write_enable,
  input  logic [7:0]            req_write_value,
  output logic [7:0]            req_read_out,
  output logic                  irq
);

  localparam int          NB        = 8 * NUM_PADS;
  localparam int          CW        = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [2:0]  NP3       = 3'(NUM_PADS);
  localparam logic [15:0] JOYP_ADDR = 16'hFF00;

  logic [NB-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NB-1:0] btn_stable_s;

  // Two-flop synchroniser; parks at released (all ones) while in reset
  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
    if (rst) begin
      sync1_d = {NB{1'b1}};
      sync2_d = {NB{1'b1}};
    end else begin
      sync1_d = btn_n;
      sync2_d = sync1_q;
    end
  end

  // Synchroniser registers
  always_ff @(posedge clk) begin
    sync1_q <= sync1_d;
    sync2_q <= sync2_d;
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_no_deb
    assign btn_stable_s = sync2_q;
  end else begin : g_deb
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [CW-1:0] cnt_q [NB];
    logic [CW-1:0] cnt_d [NB];
    logic [NB-1:0] stable_q, stable_d;

    // Per-bit counter: accept a new level only after DEBOUNCE_CYCLES differing samples in a row
    always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < NB; i++) begin
        cnt_d[i] = cnt_q[i];
        if (rst) begin
          cnt_d[i]    = {CW{1'b0}};
          stable_d[i] = 1'b1;
        end else if (sync2_q[i] == stable_q[i]) begin
          cnt_d[i] = {CW{1'b0}};
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i]    = {CW{1'b0}};
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1'b1);
        end
      end
    end

    // Debounce state registers
    always_ff @(posedge clk) begin
      stable_q <= stable_d;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end

    assign btn_stable_s = stable_q;
  end

  logic       we_q, we_d;
  logic [1:0] sel_q, sel_d, cur_q, cur_d, mlt_q, mlt_d;
  logic [3:0] lines_q, lines_d;
  logic [2:0] req_cnt_s, eff_cnt_s;
  logic       multi_s, wr_first_s;
  logic [1:0] pad_idx_s;
  logic [7:0] pad_s;
  logic [3:0] lines_s;
  logic       unused_s;

  assign unused_s = ^{req_write_value[7:6], req_write_value[3:0]};

  // Effective player count: requested count clamped to the pads present
  always_comb begin
    case (mlt_mode)
      2'd0:    req_cnt_s = 3'd1;
      2'd1:    req_cnt_s = 3'd2;
      2'd2:    req_cnt_s = 3'd4;
      2'd3:    req_cnt_s = 3'd4;
      default: req_cnt_s = 3'd1;
    endcase
    if (req_cnt_s > NP3) begin
      eff_cnt_s = NP3;
    end else begin
      eff_cnt_s = req_cnt_s;
    end
    multi_s = (eff_cnt_s > 3'd1);
  end

  // Select the current pad (never an index beyond the pads present) and form the line nibble
  always_comb begin
    pad_idx_s = (({1'b0, cur_q}) < NP3) ? cur_q : 2'b00;
    pad_s     = 8'hFF;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (pad_idx_s == 2'(p)) begin
        pad_s = btn_stable_s[8*p +: 8];
      end else begin
        pad_s = pad_s;
      end
    end
    case (sel_q)
      2'b10:   lines_s = pad_s[3:0];
      2'b01:   lines_s = pad_s[7:4];
      2'b00:   lines_s = pad_s[3:0] & pad_s[7:4];
      2'b11:   lines_s = multi_s ? (4'hF - {2'b00, cur_q}) : 4'hF;
      default: lines_s = 4'hF;
    endcase
  end

  // Control next state: edge-qualified sel load, player advance, mlt change resets cur
  always_comb begin
    wr_first_s = req_write_enable && !we_q && (req_addr_select == JOYP_ADDR);
    we_d       = req_write_enable;
    mlt_d      = mlt_mode;
    sel_d      = sel_q;
    cur_d      = cur_q;
    lines_d    = lines_s;
    if (rst) begin
      sel_d   = 2'b11;
      cur_d   = 2'b00;
      lines_d = 4'hF;
    end else begin
      if (wr_first_s) begin
        sel_d = req_write_value[5:4];
      end else begin
        sel_d = sel_q;
      end
      if (mlt_mode != mlt_q) begin
        cur_d = 2'b00;
      end else if (wr_first_s && (sel_q != 2'b11) && (req_write_value[5:4] == 2'b11)) begin
        if (({1'b0, cur_q} + 3'd1) >= eff_cnt_s) begin
          cur_d = 2'b00;
        end else begin
          cur_d = cur_q + 2'd1;
        end
      end else begin
        cur_d = cur_q;
      end
    end
  end

  // Control registers; we_q and mlt_q track their inputs even in reset so a held write is not replayed
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    mlt_q   <= mlt_d;
    sel_q   <= sel_d;
    cur_q   <= cur_d;
    lines_q <= lines_d;
  end

  assign req_read_out = (req_addr_select == JOYP_ADDR) ? {2'b11, sel_q, lines_s} : 8'hFF;
  assign irq          = !rst && (|(lines_q & ~lines_s));

endmodule

// File: tb/tb_mmio_joypad_mp.sv
// Self-checking bench for mmio_joypad_mp: directed scenarios plus random traffic,
// compared every cycle against a behavioural model for two configurations.
module tb_mmio_joypad_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] btn_n;
  logic [1:0]  mlt_mode;
  logic [15:0] addr;
  logic        we;
  logic [7:0]  wv;
  logic [7:0]  rd_a, rd_b;
  logic        irq_a, irq_b;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mmio_joypad_mp #(.NUM_PADS(4), .DEBOUNCE_CYCLES(4)) u_a (
    .clk(clk), .rst(rst), .btn_n(btn_n), .mlt_mode(mlt_mode),
    .req_addr_select(addr), .req_write_enable(we), .req_write_value(wv),
    .req_read_out(rd_a), .irq(irq_a));

  mmio_joypad_mp #(.NUM_PADS(2), .DEBOUNCE_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .btn_n(btn_n[15:0]), .mlt_mode(mlt_mode),
    .req_addr_select(addr), .req_write_enable(we), .req_write_value(wv),
    .req_read_out(rd_b), .irq(irq_b));

  // Reference model state, index 0 = u_a, 1 = u_b
  int          np [2];
  int          dc [2];
  logic [31:0] hist [2][8];   // hist[k][0] = most recent raw sample
  logic [31:0] m_stable [2];
  logic [1:0]  m_sel [2];
  logic [1:0]  m_cur [2];
  logic [3:0]  m_lq [2];
  logic        p_we;
  logic [1:0]  p_mlt;

  function automatic int eff_cnt(int k, logic [1:0] m);
    int r;
    r = (m == 2'd2) ? 4 : int'(m) + 1;
    return (r < np[k]) ? r : np[k];
  endfunction

  function automatic logic [3:0] m_lines(int k);
    logic [7:0] pad;
    pad = m_stable[k][int'(m_cur[k]) * 8 +: 8];
    case (m_sel[k])
      2'b10:   return pad[3:0];
      2'b01:   return pad[7:4];
      2'b00:   return pad[3:0] & pad[7:4];
      default: return (eff_cnt(k, mlt_mode) > 1) ? 4'(15 - int'(m_cur[k])) : 4'hF;
    endcase
  endfunction

  function automatic logic [7:0] exp_rd(int k);
    return (addr == 16'hFF00) ? {2'b11, m_sel[k], m_lines(k)} : 8'hFF;
  endfunction

  function automatic logic exp_irq(int k);
    return !rst && ((m_lq[k] & ~m_lines(k)) != 4'h0);
  endfunction

  task automatic model_step();
    logic        wr_first;
    logic [31:0] acc;
    wr_first = we && !p_we && (addr == 16'hFF00);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int j = 0; j < 8; j++) hist[k][j] = 32'hFFFF_FFFF;
        m_stable[k] = 32'hFFFF_FFFF;
        m_sel[k]    = 2'b11;
        m_cur[k]    = 2'b00;
        m_lq[k]     = 4'hF;
      end else begin
        m_lq[k] = m_lines(k);
        if (mlt_mode != p_mlt) m_cur[k] = 2'b00;
        else if (wr_first && m_sel[k] != 2'b11 && wv[5:4] == 2'b11)
          m_cur[k] = 2'((int'(m_cur[k]) + 1) % eff_cnt(k, mlt_mode));
        if (wr_first) m_sel[k] = wv[5:4];
        if (dc[k] == 0) begin
          m_stable[k] = hist[k][0];
        end else begin
          acc = 32'hFFFF_FFFF;  // bits whose last dc synchronised samples all differ
          for (int j = 1; j <= dc[k]; j++) acc &= hist[k][j] ^ m_stable[k];
          m_stable[k] ^= acc;
        end
        for (int j = 7; j > 0; j--) hist[k][j] = hist[k][j-1];
        hist[k][0] = btn_n;
      end
    end
    p_we  = we;
    p_mlt = mlt_mode;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("rd_a", rd_a, exp_rd(0));
    chk("rd_b", rd_b, exp_rd(1));
    chk("irq_a", {7'd0, irq_a}, {7'd0, exp_irq(0)});
    chk("irq_b", {7'd0, irq_b}, {7'd0, exp_irq(1)});
  endtask

  task automatic wr(input logic [7:0] v);
    addr = 16'hFF00; we = 1'b1; wv = v;
    cycle();
    we = 1'b0;
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  logic [7:0] e26a [4];
  logic [7:0] e26b [4];

  initial begin
    np[0] = 4; dc[0] = 4; np[1] = 2; dc[1] = 0;
    p_we = 1'b0; p_mlt = 2'd0;
    rst = 1'b1; btn_n = 32'hFFFF_FFFF; mlt_mode = 2'd0;
    addr = 16'hFF00; we = 1'b0; wv = 8'h00;
    e26a[0] = 8'hFE; e26a[1] = 8'hFD; e26a[2] = 8'hFC; e26a[3] = 8'hFF;
    e26b[0] = 8'hFE; e26b[1] = 8'hFF; e26b[2] = 8'hFE; e26b[3] = 8'hFF;

    // Reset state and idle read
    do_reset();
    chk("rst_rd_a", rd_a, 8'hFF);
    chk("rst_irq_a", {7'd0, irq_a}, 8'h00);
    cycle();
    chk("idle_rd_a", rd_a, 8'hFF);

    // Debounce latency: press 'right' on pad 0 with d-pad selected
    wr(8'h20);
    chk("sel10_rd_a", rd_a, 8'hEF);
    btn_n[0] = 1'b0;
    repeat (5) cycle();
    chk("deb_hold_rd", rd_a, 8'hEF);
    chk("deb_hold_irq", {7'd0, irq_a}, 8'h00);
    cycle();
    chk("deb_acc_rd", rd_a, 8'hEE);
    chk("deb_acc_irq", {7'd0, irq_a}, 8'h01);
    cycle();
    chk("deb_irq_end", {7'd0, irq_a}, 8'h00);

    // Release, then a 3-cycle glitch that must be ignored
    btn_n[0] = 1'b1;
    repeat (8) cycle();
    chk("release_rd", rd_a, 8'hEF);
    btn_n[0] = 1'b0;
    repeat (3) begin
      cycle();
      chk("glitch_irq", {7'd0, irq_a}, 8'h00);
    end
    btn_n[0] = 1'b1;
    repeat (8) begin
      cycle();
      chk("glitch_rd", rd_a, 8'hEF);
      chk("glitch_irq", {7'd0, irq_a}, 8'h00);
    end

    // Multiplayer rotation: 4 pads on u_a, 2 pads on u_b
    mlt_mode = 2'd3;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr(8'h10);
      wr(8'h30);
      chk("mp_rd_a", rd_a, e26a[i]);
      chk("mp_rd_b", rd_b, e26b[i]);
    end

    // mlt change resets cur, also over a simultaneous advance
    wr(8'h10);
    wr(8'h30);
    chk("mp_cur1_a", rd_a, 8'hFE);
    mlt_mode = 2'd1;
    cycle();
    chk("mlt_chg_rd_a", rd_a, 8'hFF);
    wr(8'h10);
    mlt_mode = 2'd3;
    addr = 16'hFF00; we = 1'b1; wv = 8'h30;
    cycle();
    we = 1'b0;
    cycle();
    chk("mlt_win_rd_a", rd_a, 8'hFF);
    chk("mlt_win_rd_b", rd_b, 8'hFF);

    // Held write: only the first cycle loads
    mlt_mode = 2'd0;
    do_reset();
    addr = 16'hFF00; we = 1'b1; wv = 8'h10;
    repeat (2) cycle();
    wv = 8'h20;
    repeat (3) cycle();
    we = 1'b0;
    cycle();
    chk("hold_rd_a", rd_a, 8'hDF);
    addr = 16'hFF01;
    cycle();
    chk("ff01_rd_a", rd_a, 8'hFF);
    chk("ff01_rd_b", rd_b, 8'hFF);
    addr = 16'hFF00;

    // Sel write exposes a held button -> single irq pulse
    do_reset();
    btn_n[4] = 1'b0;
    repeat (8) cycle();
    we = 1'b1; wv = 8'h10;
    cycle();
    chk("selw_irq_on", {7'd0, irq_a}, 8'h01);
    chk("selw_rd_a", rd_a, 8'hDE);
    we = 1'b0;
    cycle();
    chk("selw_irq_off", {7'd0, irq_a}, 8'h00);

    // Reset mid-debounce and mid-write discards the pending change
    btn_n[5] = 1'b0;
    repeat (2) cycle();
    rst = 1'b1; we = 1'b1; wv = 8'h20;
    repeat (2) cycle();
    rst = 1'b0;
    chk("rstmid_rd_a", rd_a, 8'hFF);
    chk("rstmid_irq_a", {7'd0, irq_a}, 8'h00);
    cycle();
    chk("rstmid_held_rd", rd_a, 8'hFF);
    we = 1'b0;
    cycle();
    wr(8'h10);
    repeat (8) cycle();
    btn_n = 32'hFFFF_FFFF;
    repeat (8) cycle();

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 700; i++) begin
      int b;
      if ($urandom_range(0, 2) == 0) begin
        b = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 31));
        btn_n[b] = ~btn_n[b];
      end
      we   = ($urandom_range(0, 3) == 0);
      wv   = 8'($urandom);
      addr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'hFF00;
      if ($urandom_range(0, 63) == 0) mlt_mode = 2'($urandom);
      rst  = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
